// File: rtl/goal_sram_pkg.sv
// Shared constants, FSM state type and circular address helper for the goal SRAM reader.
package goal_sram_pkg;

   localparam int unsigned GOAL_DEPTH  = 34;
   localparam int unsigned GOAL_ADDR_W = 6;
   localparam int unsigned GOAL_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      RUN,
      FLUSH
   } goal_state_t;

   // base + offset computed one bit wider, folded back into 0..GOAL_DEPTH-1
   function automatic logic [GOAL_ADDR_W-1:0] goal_wrap_addr(
      input logic [GOAL_ADDR_W-1:0] base,
      input logic [GOAL_ADDR_W-1:0] offset
   );
      logic [GOAL_ADDR_W:0] sum;
      sum = {1'b0, base} + {1'b0, offset};
      if (sum >= (GOAL_ADDR_W+1)'(GOAL_DEPTH)) begin
         sum = sum - (GOAL_ADDR_W+1)'(GOAL_DEPTH);
      end
      return sum[GOAL_ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/goal_sram_reader_if.sv
// SRAM second-port (Avalon-MM read) and output stream signals of the goal SRAM reader.
interface goal_sram_reader_if
   import goal_sram_pkg::*;
#(
   parameter int unsigned DATA_W = GOAL_DATA_W,
   parameter int unsigned ADDR_W = GOAL_ADDR_W
);
   logic [ADDR_W-1:0] sram_address;
   logic              sram_chipselect;
   logic              sram_clken;
   logic              sram_write;
   logic [1:0]        sram_byteenable;
   logic [DATA_W-1:0] sram_writedata;
   logic [DATA_W-1:0] sram_readdata;

   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_index;
   logic              out_last;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output sram_address, sram_chipselect, sram_clken, sram_write,
             sram_byteenable, sram_writedata,
      input  sram_readdata,
      output out_data, out_index, out_last, out_valid,
      input  out_ready
   );

   modport slave (
      input  sram_address, sram_chipselect, sram_clken, sram_write,
             sram_byteenable, sram_writedata,
      output sram_readdata,
      input  out_data, out_index, out_last, out_valid,
      output out_ready
   );

endinterface

// File: rtl/goal_sram_reader_skid.sv
// Two-entry skid buffer holding {data, index, last}; simultaneous push and pop keep the count.
module goal_skid_buf
   import goal_sram_pkg::*;
#(
   parameter int unsigned DATA_W = GOAL_DATA_W,
   parameter int unsigned ADDR_W = GOAL_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic [ADDR_W-1:0] push_index,
   input  logic              push_last,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic [ADDR_W-1:0] head_index,
   output logic              head_last,
   output logic [1:0]        count
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] index;
      logic              last;
   } entry_t;

   entry_t entries [2];
   logic   rd_ptr;
   logic   wr_ptr;
   logic   do_pop;

   assign do_pop = pop && (count != 2'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         entries[0] <= '0;
         entries[1] <= '0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         count      <= '0;
      end else begin
         if (push) begin
            entries[wr_ptr] <= '{data: push_data, index: push_index, last: push_last};
            wr_ptr          <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head_data  = entries[rd_ptr].data;
   assign head_index = entries[rd_ptr].index;
   assign head_last  = entries[rd_ptr].last;

endmodule

// File: rtl/goal_sram_reader.sv
// Goal SRAM read initiator: fetches a circular run of words and streams them out.
// GOAL_SRAM_READER_CHECKSUM_EN adds a running 16-bit checksum output of transferred words.
module goal_sram_reader
   import goal_sram_pkg::*;
#(
   parameter int unsigned DATA_W = GOAL_DATA_W,
   parameter int unsigned ADDR_W = GOAL_ADDR_W,
   parameter int unsigned DEPTH  = GOAL_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] length,
   output logic              busy,
   output logic              done,
   output logic              error,
   goal_sram_reader_if.master bus
`ifdef GOAL_SRAM_READER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   goal_state_t       state;
   goal_state_t       state_next;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] issued_q;
   logic              inflight_q;
   logic [ADDR_W-1:0] inflight_seq;
   logic [ADDR_W-1:0] inflight_addr;
   logic              error_q;

   logic [1:0]        count;
   logic              pop;
   logic              issue;
   logic              reject;
   logic              check_bad;
   logic              can_issue;
   logic [2:0]        occupancy;

   assign pop       = bus.out_valid && bus.out_ready;
   // A word leaving this cycle frees its slot, so steady streaming sustains one read per cycle
   assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
   assign can_issue = (issued_q < len_q) && (occupancy < 3'd2);
   assign check_bad = (len_q > ADDR_W'(DEPTH)) || (base_q >= ADDR_W'(DEPTH));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      issue      = 1'b0;
      reject     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = CHECK;
         end
         CHECK: begin
            busy = 1'b1;
            if (check_bad) begin
               reject     = 1'b1;
               done       = 1'b1;
               state_next = IDLE;
            end else if (len_q == '0) begin
               done       = 1'b1;
               state_next = IDLE;
            end else begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (can_issue) begin
               issue = 1'b1;
               if (issued_q + ADDR_W'(1) == len_q) state_next = FLUSH;
            end
         end
         FLUSH: begin
            busy = 1'b1;
            if (count == 2'd0 && !inflight_q) begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign error = error_q || reject;

   assign bus.sram_chipselect = issue;
   assign bus.sram_clken      = issue;
   assign bus.sram_address    = issue ? goal_wrap_addr(base_q, issued_q) : '0;
   assign bus.sram_write      = 1'b0;
   assign bus.sram_byteenable = '1;
   assign bus.sram_writedata  = '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         base_q        <= '0;
         len_q         <= '0;
         issued_q      <= '0;
         inflight_q    <= 1'b0;
         inflight_seq  <= '0;
         inflight_addr <= '0;
         error_q       <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            inflight_seq  <= issued_q;
            inflight_addr <= bus.sram_address;
            issued_q      <= issued_q + ADDR_W'(1);
         end
         if (state == IDLE && start) begin
            base_q   <= base;
            len_q    <= length;
            issued_q <= '0;
            error_q  <= 1'b0;
         end
         if (reject) error_q <= 1'b1;
      end
   end

   goal_skid_buf #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) skid (
      .clk        (clk),
      .reset      (reset),
      .push       (inflight_q),
      .push_data  (bus.sram_readdata),
      .push_index (inflight_addr),
      .push_last  (inflight_seq == len_q - ADDR_W'(1)),
      .pop        (pop),
      .head_data  (bus.out_data),
      .head_index (bus.out_index),
      .head_last  (bus.out_last),
      .count      (count)
   );

   assign bus.out_valid = (count != 2'd0);

`ifdef GOAL_SRAM_READER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         checksum <= '0;
      end else if (state == IDLE && start) begin
         checksum <= '0;
      end else if (pop) begin
         checksum <= checksum + bus.out_data;
      end
   end
`endif

endmodule

// File: tb/tb_goal_sram_reader.sv
// Directed self-checking bench for goal_sram_reader against a registered 34-word SRAM model.
module tb_goal_sram_reader;
   import goal_sram_pkg::*;

   localparam int unsigned DW    = 16;
   localparam int unsigned AW    = 6;
   localparam int unsigned DEPTH = 34;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base;
   logic [AW-1:0] length;
   logic          busy;
   logic          done;
   logic          error;
`ifdef GOAL_SRAM_READER_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   goal_sram_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   goal_sram_reader #(
      .DATA_W (DW),
      .ADDR_W (AW),
      .DEPTH  (DEPTH)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .base   (base),
      .length (length),
      .busy   (busy),
      .done   (done),
      .error  (error),
      .bus    (bus)
`ifdef GOAL_SRAM_READER_CHECKSUM_EN
      ,
      .checksum (checksum)
`endif
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [0:63];
   int            oob_reads = 0;

   always @(posedge clk) begin
      if (bus.sram_chipselect && bus.sram_clken) begin
         if (bus.sram_address >= AW'(DEPTH)) oob_reads = oob_reads + 1;
         bus.sram_readdata <= mem[bus.sram_address];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // mode 0: ready held high; 1: ready pattern 1,0,0 repeating; 2: ready high plus a stray start
   task automatic run_case(input string name, input int b, input int l, input int mode, input bit exp_err);
      int            cyc, got, issued, last_xfer, first_valid, done_cyc, max_out;
      int            exp_idx;
      bit            seen_done, prev_stall, exp_empty;
      logic [DW-1:0] prev_data, exp_sum, exp_data;
      logic [AW-1:0] prev_idx;

      exp_empty = exp_err || (l == 0);
      base   = AW'(b);
      length = AW'(l);
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0; got = 0; issued = 0; last_xfer = -1; first_valid = -1; done_cyc = -1;
      max_out = 0; seen_done = 1'b0; prev_stall = 1'b0; exp_sum = '0;
      prev_data = '0; prev_idx = '0;

      while (!seen_done && cyc < 300) begin
         bus.out_ready = (mode == 1) ? ((cyc % 3) == 0) : 1'b1;
         if (mode == 2 && cyc == 4) begin
            start = 1'b1; base = '0; length = AW'(1);
         end else begin
            start = 1'b0;
         end
         #1;
         if (prev_stall) begin
            check_val($sformatf("%s stall_data w%0d", name, got), 32'(bus.out_data), 32'(prev_data));
            check_val($sformatf("%s stall_idx w%0d", name, got), 32'(bus.out_index), 32'(prev_idx));
         end
         if (bus.out_valid && first_valid < 0) first_valid = cyc;
         if (bus.sram_chipselect) issued++;
         if (bus.out_valid && bus.out_ready) begin
            exp_idx  = (b + got) % DEPTH;
            exp_data = 16'h1000 + 16'(exp_idx);
            check_val($sformatf("%s idx w%0d", name, got), 32'(bus.out_index), 32'(exp_idx));
            check_val($sformatf("%s data w%0d", name, got), 32'(bus.out_data), 32'(exp_data));
            check_val($sformatf("%s last w%0d", name, got), 32'(bus.out_last), 32'(got == l - 1));
            exp_sum   = exp_sum + exp_data;
            got++;
            last_xfer = cyc;
         end
         if (issued - got > max_out) max_out = issued - got;
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_idx   = bus.out_index;
         if (done) begin
            seen_done = 1'b1;
            done_cyc  = cyc;
            check_val({name, " busy_at_done"}, 32'(busy), 32'd1);
            check_val({name, " error_at_done"}, 32'(error), 32'(exp_err));
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;

      check_val({name, " done_seen"}, 32'(seen_done), 32'd1);
      check_val({name, " word_count"}, 32'(got), exp_empty ? 32'd0 : 32'(l));
      check_val({name, " max_outstanding_ok"}, 32'(max_out <= 2), 32'd1);
      if (exp_empty) begin
         check_val({name, " done_cycle"}, 32'(done_cyc), 32'd0);
         check_val({name, " reads_issued"}, 32'(issued), 32'd0);
      end else begin
         check_val({name, " done_after_last"}, 32'(done_cyc), 32'(last_xfer + 1));
         if (mode == 0) begin
            check_val({name, " first_valid"}, 32'(first_valid), 32'd3);
            check_val({name, " done_cycle"}, 32'(done_cyc), 32'(3 + l));
         end
      end
      check_val({name, " busy_after"}, 32'(busy), 32'd0);
      check_val({name, " done_after"}, 32'(done), 32'd0);
      check_val({name, " error_held"}, 32'(error), 32'(exp_err));
`ifdef GOAL_SRAM_READER_CHECKSUM_EN
      check_val({name, " checksum"}, 32'(checksum), exp_empty ? 32'd0 : 32'(exp_sum));
`endif
   endtask

   task automatic reset_mid_run();
      bit any_done;
      base = '0; length = AW'(10); start = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      check_val("rst pre_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check_val("rst out_valid", 32'(bus.out_valid), 32'd0);
      check_val("rst busy", 32'(busy), 32'd0);
      check_val("rst chipselect", 32'(bus.sram_chipselect), 32'd0);
      any_done = done;
      repeat (5) begin
         @(posedge clk); #1;
         if (done || busy || bus.out_valid) any_done = 1'b1;
      end
      check_val("rst quiet_after", 32'(any_done), 32'd0);
   endtask

   initial begin
      for (int k = 0; k < 64; k++) mem[k] = 16'h1000 + 16'(k);
      reset = 1'b1; start = 1'b0; base = '0; length = '0; bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset busy", 32'(busy), 32'd0);
      check_val("reset done", 32'(done), 32'd0);
      check_val("reset error", 32'(error), 32'd0);
      check_val("reset out_valid", 32'(bus.out_valid), 32'd0);
      check_val("reset out_last", 32'(bus.out_last), 32'd0);
      check_val("reset chipselect", 32'(bus.sram_chipselect), 32'd0);
      check_val("reset clken", 32'(bus.sram_clken), 32'd0);
      check_val("reset address", 32'(bus.sram_address), 32'd0);
      check_val("reset out_data", 32'(bus.out_data), 32'd0);
      check_val("reset out_index", 32'(bus.out_index), 32'd0);
      check_val("tie write", 32'(bus.sram_write), 32'd0);
      check_val("tie byteenable", 32'(bus.sram_byteenable), 32'h3);
      check_val("tie writedata", 32'(bus.sram_writedata), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      run_case("b0l4", 0, 4, 0, 1'b0);
      run_case("b32l4", 32, 4, 0, 1'b0);
      run_case("b5l6stall", 5, 6, 1, 1'b0);
      run_case("len35", 0, 35, 0, 1'b1);
      run_case("base34", 34, 2, 0, 1'b1);
      run_case("len0", 3, 0, 0, 1'b0);
      run_case("restart_ignored", 10, 8, 2, 1'b0);
      reset_mid_run();
      run_case("after_rst", 1, 5, 0, 1'b0);
      run_case("full", 0, 34, 0, 1'b0);
`ifdef GOAL_SRAM_READER_CHECKSUM_EN
      check_val("full checksum_const", 32'(checksum), 32'h2231);
`endif
      run_case("b33l34stall", 33, 34, 1, 1'b0);
      run_case("b33l1", 33, 1, 0, 1'b0);
      check_val("no_oob_reads", 32'(oob_reads), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
